// File: rtl/alu_share_arbiter_if.sv
// Handshake bundle between two ALU requesters, the result consumer and alu_share_arbiter.
// The arbiter takes the slave modport; the requester/consumer side takes master.
interface alu_share_arbiter_if #(
   parameter int unsigned WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [2:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;

   logic             req1_valid;
   logic             req1_ready;
   logic [2:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_zero
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_zero
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of a shared ALU slice with a single-entry result register.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_share_arbiter_if.slave   bus
);

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e           state_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic             rsp_zero_q;

   logic             grant0;
   logic             grant1;
   logic             consume;
   logic             slot_free;
   logic             ready0;
   logic             ready1;
   logic             accept;
   logic             win_id;

   logic [2:0]       op_sel;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             slt_signed;
   logic             slt_unsigned;

`ifdef ALU_ARB_RR_EN
   // Index of the most recent winner; reset to 1 so requester 0 wins the first contention.
   logic             last_q;

   always_comb begin
      grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
      grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
   end
`else
   always_comb begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid & ~bus.req0_valid;
   end
`endif

   // The slot frees up in the same cycle the held result is consumed, so no bubble.
   always_comb begin
      consume   = (state_q == StFull) & bus.rsp_ready;
      slot_free = (state_q == StEmpty) | consume;
      ready0    = grant0 & slot_free;
      ready1    = grant1 & slot_free;
      accept    = ready0 | ready1;
      win_id    = grant1;
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;

   always_comb begin
      if (win_id) begin
         op_sel = bus.req1_op;
         a_sel  = bus.req1_a;
         b_sel  = bus.req1_b;
      end else begin
         op_sel = bus.req0_op;
         a_sel  = bus.req0_a;
         b_sel  = bus.req0_b;
      end
   end

   always_comb begin
      slt_signed   = $signed(a_sel) < $signed(b_sel);
      slt_unsigned = a_sel < b_sel;
      alu_result   = '0;
      unique case (op_sel)
         3'b000: alu_result = a_sel & b_sel;
         3'b001: alu_result = a_sel | b_sel;
         3'b010: alu_result = a_sel ^ b_sel;
         3'b011: alu_result = ~(a_sel | b_sel);
         3'b100: alu_result = a_sel + b_sel;
         3'b101: alu_result = a_sel - b_sel;
         3'b110: alu_result = {{(WIDTH-1){1'b0}}, slt_signed};
         3'b111: alu_result = {{(WIDTH-1){1'b0}}, slt_unsigned};
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StEmpty;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
         last_q       <= 1'b1;
`endif
      end else begin
         if (accept) begin
            rsp_id_q     <= win_id;
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_zero;
`ifdef ALU_ARB_RR_EN
            last_q       <= win_id;
`endif
         end
         unique case (state_q)
            StEmpty: if (accept) state_q <= StFull;
            StFull:  if (consume && !accept) state_q <= StEmpty;
            default: state_q <= StEmpty;
         endcase
      end
   end

   assign bus.rsp_valid  = (state_q == StFull);
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_zero   = rsp_zero_q;

   a_one_ready : assert property (@(posedge clk) disable iff (reset) !(ready0 && ready1));

   a_stall_hold : assert property (@(posedge clk) disable iff (reset)
      (bus.rsp_valid && !bus.rsp_ready) |=>
         (bus.rsp_valid && $stable(rsp_result_q) && $stable(rsp_id_q) && $stable(rsp_zero_q)));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a cycle model predicts grants and queues results.
// Follows the arbitration mode selected by ALU_ARB_RR_EN.
module tb_alu_share_arbiter;

   typedef struct {
      logic        id;
      logic [31:0] res;
   } exp_t;

   logic clk;
   logic reset;

   alu_share_arbiter_if #(.WIDTH(32)) bus ();

   alu_share_arbiter #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks;
   int   n_errors;
   exp_t exp_q[$];
   logic m_full;
   logic m_last;
   logic m_acc0;
   logic m_acc1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] r;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = a ^ b;
         3'd3: r = ~(a | b);
         3'd4: r = a + b;
         3'd5: r = a - b;
         3'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: r = (a < b) ? 32'd1 : 32'd0;
      endcase
      return r;
   endfunction

   // One clock: predict and compare at the falling edge, then advance past the rising edge.
   task automatic step();
      logic g0, g1, cons, sf, r0, r1;
      exp_t e;
      @(negedge clk);
`ifdef ALU_ARB_RR_EN
      g0 = bus.req0_valid & (!bus.req1_valid | m_last);
      g1 = bus.req1_valid & (!bus.req0_valid | !m_last);
`else
      g0 = bus.req0_valid;
      g1 = bus.req1_valid & !bus.req0_valid;
`endif
      cons = m_full & bus.rsp_ready;
      sf   = !m_full | cons;
      r0   = g0 & sf;
      r1   = g1 & sf;
      check_eq("req0_ready", bus.req0_ready, r0);
      check_eq("req1_ready", bus.req1_ready, r1);
      check_eq("rsp_valid", bus.rsp_valid, m_full);
      if (m_full) begin
         if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 1, 0);
         end else begin
            check_eq("rsp_id", bus.rsp_id, exp_q[0].id);
            check_eq("rsp_result", bus.rsp_result, exp_q[0].res);
            check_eq("rsp_zero", bus.rsp_zero, exp_q[0].res == 32'd0);
         end
      end
      if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
      if (r0) begin
         e.id  = 1'b0;
         e.res = alu_model(bus.req0_op, bus.req0_a, bus.req0_b);
         exp_q.push_back(e);
         m_last = 1'b0;
      end
      if (r1) begin
         e.id  = 1'b1;
         e.res = alu_model(bus.req1_op, bus.req1_a, bus.req1_b);
         exp_q.push_back(e);
         m_last = 1'b1;
      end
      m_full = r0 | r1 | (m_full & !cons);
      m_acc0 = r0;
      m_acc1 = r1;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_full = 1'b0;
      m_last = 1'b1;
      m_acc0 = 1'b0;
      m_acc1 = 1'b0;
   endtask

   task automatic set_req0(input logic v, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      bus.req0_valid = v;
      bus.req0_op    = op;
      bus.req0_a     = a;
      bus.req0_b     = b;
   endtask

   task automatic set_req1(input logic v, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      bus.req1_valid = v;
      bus.req1_op    = op;
      bus.req1_a     = a;
      bus.req1_b     = b;
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] tbl [4];
      tbl[0] = 32'h0000_0000;
      tbl[1] = 32'hFFFF_FFFF;
      tbl[2] = 32'h8000_0000;
      tbl[3] = 32'h0000_0001;
      if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   initial begin
      n_checks = 0;
      n_errors = 0;
      model_reset();
      reset = 1'b1;
      set_req0(1'b0, 3'd0, 32'd0, 32'd0);
      set_req1(1'b0, 3'd0, 32'd0, 32'd0);
      bus.rsp_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_rsp_valid", bus.rsp_valid, 0);
      check_eq("reset_rsp_id", bus.rsp_id, 0);
      check_eq("reset_rsp_result", bus.rsp_result, 0);
      check_eq("reset_rsp_zero", bus.rsp_zero, 0);
      reset = 1'b0;

      // Single ADD wrapping to zero.
      bus.rsp_ready = 1'b1;
      set_req0(1'b1, 3'd4, 32'hFFFF_FFFF, 32'd1);
      step();
      set_req0(1'b0, 3'd0, 32'd0, 32'd0);
      step();

      // Contention: req0 AND vs req1 SUB, both held valid.
      set_req0(1'b1, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
      set_req1(1'b1, 3'd5, 32'd5, 32'd7);
      repeat (5) step();

      // Backpressure with both still pending, then release.
      bus.rsp_ready = 1'b0;
      repeat (5) step();
      bus.rsp_ready = 1'b1;
      repeat (3) step();

      // req0 drops: req1 must then be granted.
      set_req0(1'b0, 3'd0, 32'd0, 32'd0);
      repeat (2) step();
      set_req1(1'b0, 3'd0, 32'd0, 32'd0);
      step();

      // Compare and NOR corner cases from requester 0 alone.
      set_req0(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd1);
      step();
      set_req0(1'b1, 3'd7, 32'hFFFF_FFFF, 32'd1);
      step();
      set_req0(1'b1, 3'd3, 32'd0, 32'd0);
      step();
      set_req0(1'b0, 3'd0, 32'd0, 32'd0);
      step();

      // Random traffic; operands only change when not pending or just accepted.
      for (int i = 0; i < 300; i++) begin
         if (!bus.req0_valid || m_acc0)
            set_req0($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick_operand(),
                     pick_operand());
         if (!bus.req1_valid || m_acc1)
            set_req1($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick_operand(),
                     pick_operand());
         bus.rsp_ready = ($urandom_range(0, 2) != 0);
         step();
      end

      // Reset while full with an accept pending.
      bus.rsp_ready = 1'b0;
      set_req0(1'b1, 3'd1, 32'h1234_0000, 32'h0000_5678);
      set_req1(1'b1, 3'd2, 32'hAAAA_AAAA, 32'h5555_5555);
      repeat (2) step();
      bus.rsp_ready = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      check_eq("midrst_rsp_valid", bus.rsp_valid, 0);
      check_eq("midrst_rsp_result", bus.rsp_result, 0);
      check_eq("midrst_req0_wins", bus.req0_ready, 1);
      repeat (4) step();
      set_req0(1'b0, 3'd0, 32'd0, 32'd0);
      set_req1(1'b0, 3'd0, 32'd0, 32'd0);
      repeat (2) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU datapath: bitwise AND/OR/XOR/NOR, add/subtract and set-less-than. Each requester presents an opcode and two operands over a valid/ready handshake. The block grants one requester per cycle, evaluates the operation and holds the result in a single-entry output register until it is consumed. It sits between the issue logic of two pipelines or units and the shared ALU slice.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req0_valid`, input, 1: requester 0 has an operation pending.
- `req0_ready`, output, 1: requester 0's operation is accepted this cycle.
- `req0_op`, input, 3: requester 0 opcode.
- `req0_a`, `req0_b`, input, WIDTH: requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as the requester 0 ports, for requester 1.
- `rsp_valid`, output, 1: the result register holds a result.
- `rsp_ready`, input, 1: the consumer takes the result this cycle.
- `rsp_id`, output, 1: index of the requester that owns the result.
- `rsp_result`, output, WIDTH: operation result.
- `rsp_zero`, output, 1: set when `rsp_result` is 0.

## Operation
**Opcodes**
- 000 AND, 001 OR, 010 XOR, 011 NOR.
- 100 ADD and 101 SUB, both modulo 2^WIDTH; there is no overflow output.
- 110 SLT (signed) and 111 SLTU (unsigned); each produces 1 or 0 in bit 0 and zero in all upper bits.

**States**
- EMPTY: the result register is free.
- FULL: the result register holds a result.

**Slot availability**
- `slot_free` = (state==EMPTY) | (rsp_valid & rsp_ready).
- When a result is consumed and a new request is accepted in the same cycle, the register reloads with the new result, the state stays FULL, and no bubble is inserted.

**Arbitration**
- Grant is combinational from the `reqN_valid` signals and the `last` pointer.
- When only one requester is valid, that requester wins.
- When both are valid, the requester that is not `last` wins (round-robin).
- `reqN_ready` = grant_N & slot_free. At most one ready is high in any cycle.

**Accept**
- On accept, the register captures `op(a,b)`, the winner's index, and the zero flag.
- `last` is updated to the winner's index.
- The state becomes FULL.

**Transitions**
- EMPTY → FULL on accept.
- FULL → EMPTY on consume with no accept.
- FULL → FULL on an accept, or while stalled. While stalled, all response outputs hold stable.

**Reset values**
- State EMPTY.
- `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0.
- `last`=1, so requester 0 wins the first contention.
- `req0_ready` and `req1_ready` follow the combinational rule, so they can rise in the reset-release cycle.

**Reset mid-operation**
- Reset discards any held result without asserting `rsp_valid`.
- An accept coincident with reset is dropped.

**Handshake rules**
- Requesters must hold `op`, `a` and `b` stable while valid and not ready.
- `rsp_ready` may be asserted while `rsp_valid` is low; it has no effect then.

## Timing
- Latency: an operation accepted in cycle t has `rsp_valid`=1 in cycle t+1.
- Throughput: one operation per cycle when `rsp_ready` is held high.
- Ready paths: `reqN_ready` depends combinationally on `rsp_ready`, `reqN_valid` and `last`. There are no combinational paths from operands to any output.
- Registered outputs: all `rsp_*` outputs are registered.

## Configuration
- `ALU_ARB_RR_EN` defined:
  - Round-robin arbitration as described above.
- `ALU_ARB_RR_EN` undefined:
  - Fixed priority: requester 0 always wins contention.
  - `last` is not implemented.
  - Requester 1 is accepted only when `req0_valid`=0.
  - All other behaviour is identical.

## Test plan
1. **Single op.** Reset, then req0 ADD a=0xFFFF_FFFF, b=1, with `rsp_ready`=1. Required: `req0_ready`=1 in cycle t; in t+1, `rsp_valid`=1, `rsp_result`=0, `rsp_zero`=1, `rsp_id`=0.
2. **Contention (RR build).** Both requesters held valid: req0 AND 0xF0F0_F0F0 & 0xFF00_FF00; req1 SUB 5-7; `rsp_ready`=1. Required: grants alternate 0,1,0,1. Results are 0xF000_F000 and 0xFFFF_FFFE respectively, tagged with the matching `rsp_id`.
3. **Backpressure.** Hold `rsp_ready`=0 for 4 cycles after the first result. Required: both readies are 0, and `rsp_*` are unchanged. On release, the consume and the next accept happen in the same cycle, and the new result appears the following cycle with no gap.
4. **Compare ops.** a=0xFFFF_FFFF, b=1: SLT → 1, SLTU → 0. NOR 0,0 → 0xFFFF_FFFF with `rsp_zero`=0.
5. **Reset mid-stream.** Assert `reset` while FULL with an accept pending. Required: next cycle `rsp_valid`=0, `rsp_result`=0, and the next contention is won by requester 0.
6. **Fixed priority (macro undefined).** Both requesters valid for 3 cycles. Required: requester 0 is granted every cycle and requester 1 is not granted until `req0_valid` drops.
